// File: rtl/mtx_hop_sched.sv
// Hop sequencer for the two-tone tag chip generator: walks a phase-increment
// table per frame, soft-resets the generator per hop and detects hop completion.
module mtx_hop_sched #(
    parameter int PHASE_WIDTH    = 24,
    parameter int HOP_ADDR_WIDTH = 4,
    parameter int FRAME_WIDTH    = 16,
    parameter int GAP_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_wr,
    input  logic [HOP_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [PHASE_WIDTH-1:0]    cfg_data,
    input  logic [HOP_ADDR_WIDTH:0]   nhops,
    input  logic [FRAME_WIDTH-1:0]    nframes,
    input  logic [GAP_WIDTH-1:0]      gap_cycles,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      hop_ready,
    output logic                      gen_srst,
    output logic [PHASE_WIDTH-1:0]    hop_phase_inc,
    output logic                      phase_tvalid,
    output logic                      phase_tlast,
    output logic                      busy,
    output logic [HOP_ADDR_WIDTH-1:0] hop_idx,
    output logic [FRAME_WIDTH-1:0]    frame_count,
    output logic                      done,
    output logic                      err
);

    localparam int DEPTH = 1 << HOP_ADDR_WIDTH;
    localparam logic [HOP_ADDR_WIDTH:0] NH_MAX =
        {1'b1, {HOP_ADDR_WIDTH{1'b0}}};
    localparam logic [GAP_WIDTH-1:0] GAP_ONE =
        {{(GAP_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_ADV
    } state_t;

    state_t state, state_nx;

    logic [PHASE_WIDTH-1:0]    tbl [DEPTH];
    logic [HOP_ADDR_WIDTH:0]   nhops_q;
    logic [FRAME_WIDTH-1:0]    nframes_q;
    logic [GAP_WIDTH-1:0]      gap_q;
    logic [GAP_WIDTH-1:0]      gap_cnt;
    logic                      hop_ready_d;

    logic                      hop_edge;
    logic                      last_hop;
    logic                      final_frame;
    logic                      nh_legal;
    logic [FRAME_WIDTH-1:0]    frame_inc;
    logic [HOP_ADDR_WIDTH-1:0] ld_idx;
    logic [PHASE_WIDTH-1:0]    ld_inc;
    logic                      abort;
    logic                      start_ok;
    logic                      start_bad;
    logic                      finish;

    assign hop_edge    = hop_ready & ~hop_ready_d;
    assign last_hop    = ({1'b0, hop_idx} == (nhops_q - 1'b1));
    assign frame_inc   = frame_count + 1'b1;
    assign final_frame = (nframes_q != '0) && (frame_inc == nframes_q);
    assign nh_legal    = (nhops != '0) && (nhops <= NH_MAX);
    assign busy        = (state != S_IDLE);

    // Index for the next LOAD; a same-cycle write to it is forwarded.
    assign ld_idx = (state == S_ADV && !last_hop) ? hop_idx + 1'b1 : '0;
    assign ld_inc = (cfg_wr && cfg_addr == ld_idx) ? cfg_data : tbl[ld_idx];

    assign phase_tlast = (state == S_RUN) && hop_edge && !stop &&
                         last_hop && final_frame;

    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        state_nx  = state;
        abort     = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        finish    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    if (nh_legal) begin
                        start_ok = 1'b1;
                        state_nx = S_LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (stop) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end else if (hop_edge) begin
                    state_nx = (gap_q == '0) ? S_ADV : S_GAP;
                end
            end
            S_GAP: begin
                if (stop) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end else if (gap_cnt == GAP_ONE) begin
                    state_nx = S_ADV;
                end
            end
            S_ADV: begin
                if (stop) begin
                    abort    = 1'b1;
                    state_nx = S_IDLE;
                end else if (last_hop && final_frame) begin
                    finish   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_LOAD;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            hop_ready_d   <= 1'b0;
            gen_srst      <= 1'b0;
            hop_phase_inc <= '0;
            phase_tvalid  <= 1'b0;
            hop_idx       <= '0;
            frame_count   <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            nhops_q       <= '0;
            nframes_q     <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
        end else begin
            state        <= state_nx;
            hop_ready_d  <= hop_ready;
            gen_srst     <= abort || (state_nx == S_LOAD);
            phase_tvalid <= (state_nx == S_RUN);
            done         <= finish;
            err          <= start_bad;
            if (start_ok) begin
                nhops_q     <= nhops;
                nframes_q   <= nframes;
                gap_q       <= gap_cycles;
                hop_idx     <= '0;
                frame_count <= '0;
            end
            if (state == S_RUN && state_nx == S_GAP) begin
                gap_cnt <= gap_q;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (state == S_ADV && !abort) begin
                hop_idx <= ld_idx;
                if (last_hop) begin
                    frame_count <= frame_inc;
                end
            end
            // Increment is registered on the edge entering LOAD, with srst.
            if (state_nx == S_LOAD) begin
                hop_phase_inc <= ld_inc;
            end
        end
    end

endmodule

// File: tb/tb_mtx_hop_sched.sv
// Scoreboard bench for mtx_hop_sched: a hop-level model queues expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mtx_hop_sched;

    localparam int PW = 24;
    localparam int HA = 4;
    localparam int FW = 16;
    localparam int GW = 16;

    localparam int K_SRST  = 0;
    localparam int K_RISE  = 1;
    localparam int K_TLAST = 2;
    localparam int K_DONE  = 3;
    localparam int K_ERR   = 4;
    localparam int K_ABORT = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [HA-1:0] cfg_addr = '0;
    logic [PW-1:0] cfg_data = '0;
    logic [HA:0]   nhops = '0;
    logic [FW-1:0] nframes = '0;
    logic [GW-1:0] gap_cycles = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          hop_ready = 1'b0;
    logic          gen_srst;
    logic [PW-1:0] hop_phase_inc;
    logic          phase_tvalid;
    logic          phase_tlast;
    logic          busy;
    logic [HA-1:0] hop_idx;
    logic [FW-1:0] frame_count;
    logic          done;
    logic          err;

    mtx_hop_sched #(
        .PHASE_WIDTH(PW),
        .HOP_ADDR_WIDTH(HA),
        .FRAME_WIDTH(FW),
        .GAP_WIDTH(GW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_wr(cfg_wr),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .nhops(nhops),
        .nframes(nframes),
        .gap_cycles(gap_cycles),
        .start(start),
        .stop(stop),
        .hop_ready(hop_ready),
        .gen_srst(gen_srst),
        .hop_phase_inc(hop_phase_inc),
        .phase_tvalid(phase_tvalid),
        .phase_tlast(phase_tlast),
        .busy(busy),
        .hop_idx(hop_idx),
        .frame_count(frame_count),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int idx;
        int fc;
        int dly;
    } ev_t;

    ev_t           q[$];
    logic [PW-1:0] mdl_tbl [16];
    string         kname [6] = '{"srst", "rise", "tlast", "done", "err", "abort"};
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            gen_lat = 20;
    int            gcnt = 0;
    int            edge_cyc = 0;
    int            low_cnt = 0;
    logic          hr_prev = 1'b0;
    logic          tv_prev = 1'b0;

    always @(posedge clk) cyc++;

    // Generator stand-in: hop_ready rises gen_lat cycles after srst,
    // and is cleared only by srst.
    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            hop_ready = 1'b0;
            gcnt = 0;
        end else if (gen_srst) begin
            hop_ready = 1'b0;
            gcnt = gen_lat;
        end else if (gcnt > 0) begin
            gcnt--;
            if (gcnt == 0) hop_ready = 1'b1;
        end
    end

    task automatic push(input int kind, input int idx, input int fc,
                        input int dly);
        ev_t e;
        e.kind = kind;
        e.idx = idx;
        e.fc = fc;
        e.dly = dly;
        q.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        bit ok;
        int d;
        checks++;
        d = (kind == K_RISE) ? low_cnt : cyc - edge_cyc;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s @%0d: got event idx=%0d fc=%0d, required none",
                     kname[kind], cyc, hop_idx, frame_count);
            return;
        end
        e = q.pop_front();
        ok = (e.kind == kind);
        if (ok) begin
            if (e.idx >= 0) ok = ok && (int'(hop_idx) == e.idx);
            if (e.fc >= 0) ok = ok && (int'(frame_count) == e.fc);
            if (e.dly >= 0) ok = ok && (d == e.dly);
            case (kind)
                K_SRST:  ok = ok && busy && (hop_phase_inc == mdl_tbl[e.idx]);
                K_RISE:  ok = ok && busy;
                K_TLAST: ok = ok && busy && phase_tvalid;
                default: ok = ok && !busy;
            endcase
        end
        if (!ok) begin
            errors++;
            $display("FAIL %s @%0d: got idx=%0d fc=%0d inc=%06h busy=%0b tv=%0b dly=%0d, required %s idx=%0d fc=%0d inc=%06h dly=%0d",
                     kname[kind], cyc, hop_idx, frame_count, hop_phase_inc,
                     busy, phase_tvalid, d, kname[e.kind], e.idx, e.fc,
                     (e.idx >= 0) ? mdl_tbl[e.idx & 15] : '0, e.dly);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (hop_ready && !hr_prev) edge_cyc = cyc;
            if (phase_tlast) observe(K_TLAST);
            if (gen_srst) observe(busy ? K_SRST : K_ABORT);
            if (phase_tvalid && !tv_prev) observe(K_RISE);
            if (done) observe(K_DONE);
            if (err) observe(K_ERR);
            low_cnt = phase_tvalid ? 0 : low_cnt + 1;
        end
        hr_prev = hop_ready;
        tv_prev = phase_tvalid;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic wr_tbl(input int a, input logic [PW-1:0] d);
        cfg_wr = 1'b1;
        cfg_addr = a[HA-1:0];
        cfg_data = d;
        mdl_tbl[a] = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    // Expected events of a finite run, derived hop by hop.
    task automatic plan_run(input int nh, input int nf, input int gp);
        for (int f = 0; f < nf; f++) begin
            for (int h = 0; h < nh; h++) begin
                int dl;
                dl = (f == 0 && h == 0) ? -1 : gp + 2;
                push(K_SRST, h, f, dl);
                push(K_RISE, h, f, dl);
                if (f == nf - 1 && h == nh - 1) push(K_TLAST, h, f, -1);
            end
        end
        push(K_DONE, 0, nf, gp + 2);
    endtask

    task automatic do_start(input int nh, input int nf, input int gp);
        nhops = nh[HA:0];
        nframes = nf[FW-1:0];
        gap_cycles = gp[GW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d events pending after %0d cycles, required 0",
                     name, q.size(), budget);
            q.delete();
        end
    endtask

    task automatic wait_run_idx(input int idx, input string name);
        int n;
        n = 0;
        while (!(phase_tvalid && !hop_ready && int'(hop_idx) == idx) && n < 2000) begin
            tick();
            n++;
        end
        chk({name, "_reach"}, (n < 2000), 1);
    endtask

    function automatic longint all_out();
        return {gen_srst, hop_phase_inc, phase_tvalid, phase_tlast, busy,
                hop_idx, frame_count, done, err};
    endfunction

    initial begin
        tick(3);
        chk("reset_outputs", all_out(), 0);
        reset = 1'b0;
        tick(2);
        for (int i = 0; i < 16; i++) wr_tbl(i, PW'($urandom));

        // Single frame with a known table
        wr_tbl(0, 24'h001000);
        wr_tbl(1, 24'h002000);
        wr_tbl(2, 24'h003000);
        gen_lat = 100;
        plan_run(3, 1, 0);
        do_start(3, 1, 0);
        drain(1000, "single_frame");
        tick(3);
        chk("single_frame_idle", busy, 0);

        // Gap timing
        gen_lat = 30;
        plan_run(3, 2, 5);
        do_start(3, 2, 5);
        drain(1000, "gap5");
        tick(3);
        chk("gap5_idle", busy, 0);

        // Continuous mode, then stop mid-RUN
        gen_lat = 25;
        for (int k = 0; k < 7; k++) begin
            push(K_SRST, k % 2, k / 2, (k == 0) ? -1 : 2);
            push(K_RISE, k % 2, k / 2, (k == 0) ? -1 : 2);
        end
        do_start(2, 0, 0);
        drain(1000, "continuous");
        tick(5);
        chk("cont_in_run", phase_tvalid && !hop_ready, 1);
        push(K_ABORT, 0, 3, -1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(20);
        chk("stop_abort_seen", q.size(), 0);
        chk("stop_idle", {busy, phase_tvalid}, 0);
        chk("stop_hold_idx", hop_idx, 0);
        chk("stop_hold_fc", frame_count, 3);

        // Illegal and ignored commands
        push(K_ERR, -1, -1, -1);
        do_start(0, 1, 0);
        drain(10, "err_nhops0");
        push(K_ERR, -1, -1, -1);
        do_start(17, 1, 0);
        drain(10, "err_nhops17");
        tick(3);
        chk("err_busy", busy, 0);
        nhops = 5'd2;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        tick(3);
        chk("start_stop_same", busy, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(3);
        chk("stop_in_idle", gen_srst || busy, 0);

        gen_lat = 20;
        plan_run(4, 1, 2);
        do_start(4, 1, 2);
        wait_run_idx(1, "start_busy");
        do_start(0, 1, 0);
        chk("start_busy_idx", hop_idx, 1);
        drain(1000, "start_busy");

        gen_lat = 10;
        plan_run(2, 1, 48);
        do_start(2, 1, 48);
        drain(1000, "hold_high");

        // Mid-run table write
        gen_lat = 40;
        plan_run(3, 1, 1);
        do_start(3, 1, 1);
        wait_run_idx(0, "wr_mid");
        wr_tbl(1, 24'hABCDEF);
        drain(1000, "wr_mid");

        // Reset in GAP, then restart from hop 0
        gen_lat = 15;
        plan_run(3, 1, 30);
        do_start(3, 1, 30);
        wait_run_idx(0, "rst_gap");
        begin
            int n;
            n = 0;
            while (!(hop_ready && !phase_tvalid) && n < 200) begin
                tick();
                n++;
            end
        end
        tick(5);
        chk("rst_in_gap", {busy, phase_tvalid}, 10'b10);
        q.delete();
        reset = 1'b1;
        tick();
        chk("rst_gap_outputs", all_out(), 0);
        reset = 1'b0;
        tick(2);
        plan_run(3, 1, 0);
        do_start(3, 1, 0);
        drain(1000, "after_reset");

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            int nh, nf, gp;
            nh = $urandom_range(1, 16);
            nf = $urandom_range(1, 3);
            gp = $urandom_range(0, 6);
            gen_lat = $urandom_range(3, 20);
            for (int i = 0; i < 16; i++) wr_tbl(i, PW'($urandom));
            plan_run(nh, nf, gp);
            do_start(nh, nf, gp);
            drain(nh * nf * (gen_lat + gp + 6) + 50, "random");
            tick(3);
            chk("random_idle", busy, 0);
        end

        tick(10);
        chk("no_stray_events", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
